// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Shared IEEE-754 single-precision constants and converter states.
//  Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;

    // Field slices of a packed single-precision word
    localparam int SIGN_BIT = EXP_W + FRAC_W;
    localparam int EXP_MSB  = EXP_W + FRAC_W - 1;
    localparam int EXP_LSB  = FRAC_W;
    localparam int FRAC_MSB = FRAC_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } norm_state_t;

endpackage
`default_nettype wire

// File: rtl/ieee754_round_rne.sv
`default_nettype none
// ============================================================================
//  Module   : ieee754_round_rne
//  Purpose  : Round-to-nearest-even on a fraction with guard and sticky bits.
//  Revision : 1.0 - initial release
// ============================================================================
module ieee754_round_rne
    import fp_pkg::*;
(
    input  logic [FRAC_W-1:0] frac_in,
    input  logic              guard,
    input  logic              sticky,
    output logic [FRAC_W-1:0] frac_out,
    output logic              carry,
    output logic              inexact
);

    logic round_up;

    // Ties (guard set, sticky clear) round toward an even fraction
    assign round_up          = guard & (sticky | frac_in[0]);
    assign {carry, frac_out} = {1'b0, frac_in} + {{FRAC_W{1'b0}}, round_up};
    assign inexact           = guard | sticky;

endmodule
`default_nettype wire

// File: rtl/int_to_ieee754_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : int_to_ieee754_normalizer
//  Purpose  : Bit-serial signed int32 to IEEE-754 single conversion (RNE).
//  Revision : 1.0 - initial release
// ============================================================================
module int_to_ieee754_normalizer #(
    parameter int EXP_BIAS = fp_pkg::EXP_BIAS,
    parameter int INT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_int,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_float,
    output logic             zero,
    output logic             inexact
);

    localparam int EW      = fp_pkg::EXP_W;
    localparam int FW      = fp_pkg::FRAC_W;
    localparam int FLOAT_W = 1 + EW + FW;
    localparam logic [EW-1:0] EXP_START = EW'(EXP_BIAS + INT_W - 1);

    fp_pkg::norm_state_t state_q, state_d;
    logic                sign_q, sign_d;
    logic [INT_W-1:0]    mag_q, mag_d;
    logic [EW-1:0]       exp_q, exp_d;
    logic [FLOAT_W-1:0]  float_q, float_d;
    logic                zero_q, zero_d;
    logic                inexact_q, inexact_d;

    logic [INT_W-1:0]    mag_in;
    logic [FW-1:0]       frac_rnd;
    logic                rnd_carry;
    logic                rnd_inexact;

    // Unsigned negate maps -2^31 onto 0x80000000 without overflow
    assign mag_in = in_int[INT_W-1] ? (~in_int + 1'b1) : in_int;

    ieee754_round_rne u_round (
        .frac_in  (mag_q[INT_W-2 -: FW]),
        .guard    (mag_q[INT_W-2-FW]),
        .sticky   (|mag_q[INT_W-3-FW:0]),
        .frac_out (frac_rnd),
        .carry    (rnd_carry),
        .inexact  (rnd_inexact)
    );

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        float_d   = float_q;
        zero_d    = zero_q;
        inexact_d = inexact_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            fp_pkg::ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sign_d    = in_int[INT_W-1];
                    mag_d     = mag_in;
                    exp_d     = EXP_START;
                    inexact_d = 1'b0;
                    if (mag_in == '0) begin
                        float_d = '0;
                        zero_d  = 1'b1;
                        state_d = fp_pkg::ST_DONE;
                    end else begin
                        zero_d  = 1'b0;
                        state_d = fp_pkg::ST_SHIFT;
                    end
                end
            end

            fp_pkg::ST_SHIFT: begin
                if (mag_q[INT_W-1]) begin
                    state_d = fp_pkg::ST_ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 1'b1;
                end
            end

            // Exponent tops out at bias+31, so the rounding carry cannot overflow
            fp_pkg::ST_ROUND: begin
                float_d   = {sign_q, exp_q + EW'(rnd_carry), frac_rnd};
                zero_d    = 1'b0;
                inexact_d = rnd_inexact;
                state_d   = fp_pkg::ST_DONE;
            end

            fp_pkg::ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = fp_pkg::ST_IDLE;
                end
            end

            default: state_d = fp_pkg::ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= fp_pkg::ST_IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            exp_q     <= '0;
            float_q   <= '0;
            zero_q    <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            float_q   <= float_d;
            zero_q    <= zero_d;
            inexact_q <= inexact_d;
        end
    end

    assign out_float = float_q;
    assign zero      = zero_q;
    assign inexact   = inexact_q;

endmodule
`default_nettype wire

// File: tb/tb_int_to_ieee754_normalizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_to_ieee754_normalizer
//  Purpose  : Self-checking bench with directed vectors and a randomized sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_to_ieee754_normalizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_int = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_float;
    logic        zero;
    logic        inexact;

    int n_checks = 0;
    int n_fail   = 0;

    int_to_ieee754_normalizer #(
        .EXP_BIAS (127),
        .INT_W    (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_int    (in_int),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_float (out_float),
        .zero      (zero),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: real-number view of the conversion using plain integer arithmetic
    task automatic ref_convert(input logic [31:0] v, output logic [31:0] f,
                               output bit inex, output int lat);
        longint m, mant, rem, half;
        int     e, sh;
        bit     s;
        s = v[31];
        m = s ? -longint'($signed(v)) : longint'(v);
        if (m == 0) begin
            f = 32'h0; inex = 1'b0; lat = 0;
            return;
        end
        e = 0;
        while ((longint'(1) << (e + 1)) <= m) e++;
        lat = (31 - e) + 2;
        rem = 0;
        if (e <= 23) begin
            mant = m << (23 - e);
        end else begin
            sh   = e - 23;
            mant = m >> sh;
            rem  = m & ((longint'(1) << sh) - 1);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && mant[0])) mant++;
            if (mant == (longint'(1) << 24)) begin
                mant = mant >> 1;
                e++;
            end
        end
        f    = {s, 8'(e + 127), mant[22:0]};
        inex = (rem != 0);
    endtask

    // One full transaction: accept, measure latency, check result, hand off
    task automatic run_op(input logic [31:0] v, input logic [31:0] ef, input bit einex,
                          input int elat, input int hold, input bit early_ready);
        int lat;
        @(negedge clk);
        check_value("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        in_int    = v;
        out_ready = early_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_int   = $urandom;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_value("latency", 64'(lat), 64'(elat));
        check_value("out_float", 64'(out_float), 64'(ef));
        check_value("zero", 64'(zero), 64'(ef == 32'h0));
        check_value("inexact", 64'(inexact), 64'(einex));
        check_value("in_ready_busy", 64'(in_ready), 64'd0);
        if (!early_ready) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_int   = $urandom;
                @(posedge clk);
                #1;
                check_value("stall_valid", 64'(out_valid), 64'd1);
                check_value("stall_float", 64'(out_float), 64'(ef));
                check_value("stall_ready", 64'(in_ready), 64'd0);
            end
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check_value("handoff_valid", 64'(out_valid), 64'd0);
        check_value("handoff_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_rand(input logic [31:0] v, input int hold, input bit early_ready);
        logic [31:0] f;
        bit          inex;
        int          lat;
        ref_convert(v, f, inex, lat);
        run_op(v, f, inex, lat, hold, early_ready);
    endtask

    initial begin
        logic [31:0] v;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_in_ready", 64'(in_ready), 64'd1);
        check_value("rst_out_valid", 64'(out_valid), 64'd0);
        check_value("rst_out_float", 64'(out_float), 64'd0);
        check_value("rst_zero", 64'(zero), 64'd0);
        check_value("rst_inexact", 64'(inexact), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h0000_0001, 32'h3F80_0000, 1'b0, 33, 0, 1'b0);
        run_op(32'h8000_0000, 32'hCF00_0000, 1'b0, 2, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33, 0, 1'b1);
        run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 0, 0, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 3, 0, 1'b0);
        run_op(32'h0100_0001, 32'h4B80_0000, 1'b1, 9, 0, 1'b0);
        run_op(32'h0000_0005, 32'h40A0_0000, 1'b0, 31, 5, 1'b0);

        // Asynchronous reset in the middle of normalizing in_int=1
        @(negedge clk);
        in_valid = 1'b1;
        in_int   = 32'h0000_0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_value("midrst_out_valid", 64'(out_valid), 64'd0);
        check_value("midrst_in_ready", 64'(in_ready), 64'd1);
        check_value("midrst_out_float", 64'(out_float), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h0000_0005, 32'h40A0_0000, 1'b0, 31, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            run_rand(v, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
